// File: rtl/led_counter_pkg.sv
// Shared mode encoding and sizing helper for the LED pattern counter.
package led_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_RING    = 2'b10,
    MODE_JOHNSON = 2'b11
  } mode_e;

  // Prescaler width: enough bits to hold DIV-1, never narrower than one bit.
  function automatic int presc_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_pattern_counter_tick_gen.sv
// Free-running prescaler producing a combinational step strobe every DIV enabled cycles.
module tick_gen
  import led_counter_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int               CW   = presc_width(DIV);
  localparam logic [CW-1:0]    LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  assign step = en && (r_count == LAST);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst || clr) begin
      r_count <= '0;
    end else if (step) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_counter.sv
// LED counter/pattern generator: up, down, one-hot ring or Johnson, advanced on prescaled steps.
module led_pattern_counter
  import led_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] outputLed,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  logic             w_step;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic [WIDTH-1:0] r_led;
  logic             r_tick;
  logic             r_wrap;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (w_step)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    w_next = r_led;
    w_wrap = 1'b0;
    case (mode)
      MODE_UP: begin
        w_next = r_led + WIDTH'(1);
        w_wrap = (r_led == '1);
      end
      MODE_DOWN: begin
        w_next = r_led - WIDTH'(1);
        w_wrap = (r_led == '0);
      end
      MODE_RING: begin
        // An all-zero register would rotate forever as zero, so seed it instead.
        if (r_led == '0) begin
          w_next = WIDTH'(1);
        end else begin
          w_next = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
          w_wrap = r_led[WIDTH-1];
        end
      end
      MODE_JOHNSON: begin
        w_next = {r_led[WIDTH-2:0], ~r_led[WIDTH-1]};
        w_wrap = (r_led == MSB_ONLY);
      end
      default: ;
    endcase
  end

  // Load beats a coincident step; the prescaler is cleared by the same strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_led  <= load_val;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_step) begin
      r_led  <= w_next;
      r_tick <= 1'b1;
      r_wrap <= w_wrap;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign outputLed = r_led;
  assign tick      = r_tick;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_led_pattern_counter.sv
// Bench for led_pattern_counter: directed table, corner sequences, random run against an arithmetic model.
module tb_led_pattern_counter;

  localparam int W0 = 8;
  localparam int D0 = 4;
  localparam int W1 = 4;
  localparam int D1 = 1;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] led0;
  logic       tick0;
  logic       wrap0;
  logic [3:0] led1;
  logic       tick1;
  logic       wrap1;

  led_pattern_counter #(.WIDTH(W0), .DIV(D0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .load      (load),
    .load_val  (load_val),
    .outputLed (led0),
    .tick      (tick0),
    .wrap      (wrap0)
  );

  led_pattern_counter #(.WIDTH(W1), .DIV(D1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .load      (load),
    .load_val  (load_val[3:0]),
    .outputLed (led1),
    .tick      (tick1),
    .wrap      (wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state, one slot per DUT.
  int m_presc [2];
  int m_led   [2];
  int m_tick  [2];
  int m_wrap  [2];

  typedef struct {
    logic       en;
    logic       load;
    logic [1:0] mode;
    logic [7:0] lval;
    int         cyc;
    logic [7:0] led;
    logic       tk;
    logic       wr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic e, input logic l, input logic [1:0] m, input logic [7:0] lv,
                     input int c, input logic [7:0] led, input logic t, input logic w);
    vec_t v;
    v.en = e; v.load = l; v.mode = m; v.lval = lv;
    v.cyc = c; v.led = led; v.tk = t; v.wr = w;
    vecs.push_back(v);
  endtask

  // Pattern rules expressed as plain arithmetic on an integer value of w bits.
  function automatic int next_pat(input int md, input int v, input int w, output int wr);
    int top;
    int half;
    int nv;
    top  = 1 << w;
    half = top / 2;
    nv   = v;
    wr   = 0;
    case (md)
      0: begin nv = (v + 1) % top;       wr = (v == top - 1) ? 1 : 0; end
      1: begin nv = (v + top - 1) % top; wr = (v == 0) ? 1 : 0;       end
      2: begin
        if (v == 0) nv = 1;
        else begin
          nv = (v * 2) % top + ((v >= half) ? 1 : 0);
          wr = (v >= half) ? 1 : 0;
        end
      end
      default: begin
        nv = (v * 2) % top + ((v >= half) ? 0 : 1);
        wr = (v == half) ? 1 : 0;
      end
    endcase
    return nv;
  endfunction

  task automatic model_edge(input int k, input int w, input int d);
    int wr;
    if (rst) begin
      m_presc[k] = 0; m_led[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end else if (load) begin
      m_led[k] = int'(load_val) % (1 << w);
      m_presc[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end else if (en && m_presc[k] == d - 1) begin
      m_presc[k] = 0;
      m_tick[k]  = 1;
      m_led[k]   = next_pat(int'(mode), m_led[k], w, wr);
      m_wrap[k]  = wr;
    end else begin
      if (en) m_presc[k] = m_presc[k] + 1;
      m_tick[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0, W0, D0);
    model_edge(1, W1, D1);
    #1;
  endtask

  task automatic run_check(input int n, input int led, input int tk, input string name);
    for (int c = 0; c < n; c++) begin
      cycle();
      if (c < n - 1) check({name, " idle tick"}, int'(tick0), 0);
    end
    check({name, " led"}, int'(led0), led);
    check({name, " tick"}, int'(tick0), tk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_presc[k] = 0; m_led[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'd0; load_val = 8'h00;
    cycle();
    cycle();
    check("reset led0", int'(led0), 0);
    check("reset tick0", int'(tick0), 0);
    check("reset wrap0", int'(wrap0), 0);
    check("reset led1", int'(led1), 0);
    rst = 1'b0;

    // Up count from reset, load/wrap in up and down, ring and Johnson sequences.
    add(1, 0, 2'd0, 8'h00, 4, 8'h01, 1, 0);
    add(1, 0, 2'd0, 8'h00, 4, 8'h02, 1, 0);
    add(1, 0, 2'd0, 8'h00, 4, 8'h03, 1, 0);
    add(1, 1, 2'd0, 8'hFE, 1, 8'hFE, 0, 0);
    add(1, 0, 2'd0, 8'h00, 4, 8'hFF, 1, 0);
    add(1, 0, 2'd0, 8'h00, 4, 8'h00, 1, 1);
    add(1, 0, 2'd1, 8'h00, 4, 8'hFF, 1, 1);
    add(1, 1, 2'd2, 8'h00, 1, 8'h00, 0, 0);
    add(1, 0, 2'd2, 8'h00, 4, 8'h01, 1, 0);
    add(1, 0, 2'd2, 8'h00, 4, 8'h02, 1, 0);
    add(1, 0, 2'd2, 8'h00, 4, 8'h04, 1, 0);
    add(1, 0, 2'd2, 8'h00, 4, 8'h08, 1, 0);
    add(1, 0, 2'd2, 8'h00, 4, 8'h10, 1, 0);
    add(1, 0, 2'd2, 8'h00, 4, 8'h20, 1, 0);
    add(1, 0, 2'd2, 8'h00, 4, 8'h40, 1, 0);
    add(1, 0, 2'd2, 8'h00, 4, 8'h80, 1, 0);
    add(1, 0, 2'd2, 8'h00, 4, 8'h01, 1, 1);
    add(1, 1, 2'd3, 8'h00, 1, 8'h00, 0, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'h01, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'h03, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'h07, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'h0F, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'h1F, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'h3F, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'h7F, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'hFF, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'hFE, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'hFC, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'hF8, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'hF0, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'hE0, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'hC0, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'h80, 1, 0);
    add(1, 0, 2'd3, 8'h00, 4, 8'h00, 1, 1);

    foreach (vecs[i]) begin
      en = vecs[i].en; load = vecs[i].load; mode = vecs[i].mode; load_val = vecs[i].lval;
      for (int c = 0; c < vecs[i].cyc; c++) begin
        cycle();
        if (c < vecs[i].cyc - 1) begin
          check($sformatf("row%0d idle tick", i), int'(tick0), 0);
          check($sformatf("row%0d idle wrap", i), int'(wrap0), 0);
        end else begin
          check($sformatf("row%0d led", i), int'(led0), int'(vecs[i].led));
          check($sformatf("row%0d tick", i), int'(tick0), int'(vecs[i].tk));
          check($sformatf("row%0d wrap", i), int'(wrap0), int'(vecs[i].wr));
        end
      end
    end

    // Enable gap with the prescaler parked at 2.
    en = 1'b1; load = 1'b1; mode = 2'd0; load_val = 8'h00;
    cycle();
    check("gap load wrap", int'(wrap0), 0);
    load = 1'b0;
    run_check(2, 8'h00, 0, "gap pre");
    en = 1'b0;
    run_check(10, 8'h00, 0, "gap hold");
    en = 1'b1;
    run_check(1, 8'h00, 0, "gap resume1");
    run_check(1, 8'h01, 1, "gap resume2");

    // Load on the very edge that would otherwise step.
    run_check(3, 8'h01, 0, "ldstep pre");
    load = 1'b1; load_val = 8'h5A;
    run_check(1, 8'h5A, 0, "ldstep load");
    load = 1'b0;
    run_check(4, 8'h5B, 1, "ldstep after");

    // Reset mid-count wins over load and enable.
    run_check(2, 8'h5B, 0, "rst pre");
    rst = 1'b1; load = 1'b1; load_val = 8'h33;
    cycle();
    check("rst led", int'(led0), 0);
    check("rst tick", int'(tick0), 0);
    check("rst wrap", int'(wrap0), 0);
    rst = 1'b0; load = 1'b0;
    run_check(4, 8'h01, 1, "rst first");

    // DIV=1 instance ticks on every enabled cycle.
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("div1 tick high", int'(tick1), 1);
    end
    en = 1'b0;
    cycle();
    check("div1 tick low", int'(tick1), 0);

    // Random traffic against the model, both instances.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(199) == 0);
      load     = ($urandom_range(29) == 0);
      en       = ($urandom_range(9) < 8);
      if ($urandom_range(19) == 0) mode = 2'($urandom_range(3));
      load_val = 8'($urandom);
      cycle();
      check("rand led0", int'(led0), m_led[0]);
      check("rand tick0", int'(tick0), m_tick[0]);
      check("rand wrap0", int'(wrap0), m_wrap[0]);
      check("rand led1", int'(led1), m_led[1]);
      check("rand tick1", int'(tick1), m_tick[1]);
      check("rand wrap1", int'(wrap1), m_wrap[1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
